fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the control decoder in the single-cycle RV32 core. It owns the PC register and runs a multi-cycle request/response handshake with instruction memory. It presents a held instruction, with opcode/funct3/funct7 split out, to the decoder. On commit it computes the next PC from npc_op and s_npc_offset, which the decoder produces.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_npc.sv | 23 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_defs: shared next-PC selectors, fetch FSM encodings and the NOP word
package fetch_defs;
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] S_REQ   = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_VALID = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;
    localparam logic [31:0] NOP    = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_if: instruction-memory request/response bus
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit_npc.sv
// npc_calc: next-PC selection from decoder controls (pc4 / branch / jump)
module npc_calc
    import fetch_defs::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [1:0]  npc_op,
    input  logic        s_npc_offset,
    input  logic        br_taken,
    output logic [31:0] npc
);
    logic [31:0] w_seq;
    logic [31:0] w_rel;
    logic [31:0] w_reg;
    assign w_seq = pc + 32'd4;
    assign w_rel = pc + imm;
    assign w_reg = (rs1_data + imm) & ~32'h1;
    // unused encoding 2'b11 falls through to sequential fetch
    always_comb
        npc = (npc_op == NPC_BEQ) ? (br_taken ? w_rel : w_seq) :
              (npc_op == NPC_JMP) ? (s_npc_offset ? w_reg : w_rel) : w_seq;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, imem handshake FSM, instruction latch and retire counter
module fetch_unit
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    fetch_if.master          imem,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    input  logic             commit,
    input  logic [1:0]       npc_op,
    input  logic             s_npc_offset,
    input  logic             br_taken,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(TIMEOUT);
    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic             r_valid;
    logic             r_err;
    logic             r_run;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_npc;
    // r_run keeps the request low during reset and releases it one cycle after
    assign imem.req   = r_run && (r_state == S_REQ);
    assign imem.addr  = r_pc;
    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign opcode     = r_inst[6:0];
    assign funct3     = r_inst[14:12];
    assign funct7     = r_inst[31:25];
    assign pc         = r_pc;
    assign pc4        = r_pc + 32'd4;
    assign fetch_err  = r_err;
    assign retired    = r_retired;
    npc_calc u_npc (
        .pc          (r_pc),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .npc_op      (npc_op),
        .s_npc_offset(s_npc_offset),
        .br_taken    (br_taken),
        .npc         (w_npc)
    );
    // fetch FSM: request, wait for data (with timeout), hold until commit, or halt on error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_inst    <= NOP;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_run     <= 1'b0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_REQ: begin
                    if (imem.req && imem.gnt) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        r_inst  <= imem.rdata;
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_VALID: begin
                    if (commit) begin
                        r_retired <= r_retired + 1'b1;
                        r_valid   <= 1'b0;
                        if (w_npc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_pc    <= w_npc;
                            r_state <= S_REQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (fetch addresses queued by a PC model)
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        commit;
    logic [1:0]  npc_op;
    logic        s_npc_offset;
    logic        br_taken;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        fetch_err;
    logic [31:0] retired;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    int          m_ret;

    fetch_if imem();

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .pc(pc), .pc4(pc4), .commit(commit), .npc_op(npc_op),
        .s_npc_offset(s_npc_offset), .br_taken(br_taken), .imm(imm),
        .rs1_data(rs1_data), .fetch_err(fetch_err), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output logic [31:0] e);
        int n = 0;
        while (!imem.req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem.req, 1);
        e = 32'hffff_ffff;
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else begin
            e = exp_q.pop_front();
            m_pc = e;
            check("req_addr", imem.addr, e);
        end
    endtask

    task automatic fetch(input logic [31:0] data, input int gd, input int rvd, input bit rv_in_gnt);
        logic [31:0] e;
        wait_req(e);
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            check("req_hold", {imem.req, imem.addr}, {1'b1, e});
        end
        imem.gnt = 1'b1;
        imem.rvalid = rv_in_gnt;
        imem.rdata = rv_in_gnt ? 32'hdead_beef : data;
        @(negedge clk);
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        if (rv_in_gnt) check("rv_in_gnt_ignored", {inst_valid, imem.req}, 2'b00);
        for (int i = 0; i < rvd; i++) @(negedge clk);
        imem.rvalid = 1'b1;
        imem.rdata = data;
        @(negedge clk);
        imem.rvalid = 1'b0;
        check("inst_valid", inst_valid, 1);
        check("inst", inst, data);
        check("fields", {funct7, funct3, opcode}, {data[31:25], data[14:12], data[6:0]});
        check("pc", pc, e);
        check("pc4", pc4, e + 32'd4);
    endtask

    task automatic do_commit(input logic [1:0] op, input bit off, input bit taken,
                             input logic [31:0] im, input logic [31:0] rs1);
        logic [31:0] n;
        case (op)
            2'b01:   n = taken ? m_pc + im : m_pc + 32'd4;
            2'b10:   n = off ? ((rs1 + im) & 32'hffff_fffe) : m_pc + im;
            default: n = m_pc + 32'd4;
        endcase
        npc_op = op;
        s_npc_offset = off;
        br_taken = taken;
        imm = im;
        rs1_data = rs1;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        m_ret++;
        check("retired", retired, m_ret);
        check("valid_clear", inst_valid, 0);
        if (n[1:0] == 2'b00) begin
            exp_q.push_back(n);
            check("no_err", fetch_err, 0);
        end else begin
            check("misalign_err", fetch_err, 1);
            check("halt_pc", pc, m_pc);
        end
    endtask

    initial begin
        logic [31:0] e;
        int n;
        rst = 1'b1;
        commit = 1'b0;
        npc_op = 2'b00;
        s_npc_offset = 1'b0;
        br_taken = 1'b0;
        imm = '0;
        rs1_data = '0;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        m_ret = 0;
        repeat (2) @(negedge clk);
        check("rst_state", {imem.req, inst_valid, fetch_err}, 3'b000);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h13);
        check("rst_retired", retired, 0);
        rst = 1'b0;
        exp_q.push_back(32'h0);
        fetch(32'h0050_0093, 0, 0, 0);
        do_commit(2'b00, 0, 0, 0, 0);
        fetch(32'h0000_0013, 0, 0, 0);
        do_commit(2'b10, 0, 0, 32'h0000_00fc, 0);
        fetch(32'h1234_5063, 0, 0, 0);
        do_commit(2'b01, 0, 1, 32'hffff_fff8, 0);
        fetch(32'hfe00_8ae3, 5, 0, 0);
        do_commit(2'b01, 0, 1, 32'h8, 0);
        fetch(32'h0020_8663, 0, 0, 1);
        do_commit(2'b01, 0, 0, 32'hffff_fff8, 0);
        fetch(32'h4030_d093, 0, 3, 0);
        do_commit(2'b11, 1, 1, 32'h40, 32'h40);
        fetch(32'h0000_0067, 0, 0, 0);
        do_commit(2'b10, 1, 0, 32'h1, 32'h1ff);
        fetch(32'h0040_80e7, 0, 0, 0);
        do_commit(2'b10, 1, 0, 32'h4, 32'h1003);
        repeat (5) @(negedge clk);
        check("halt_frozen", {imem.req, inst_valid, fetch_err}, 3'b001);
        check("halt_pc_hold", pc, 32'h200);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clears_err", fetch_err, 0);
        check("rst_pc2", pc, 32'h0);
        rst = 1'b0;
        m_ret = 0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        fetch(32'h0000_0013, 0, 0, 0);
        do_commit(2'b00, 0, 0, 0, 0);
        wait_req(e);
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        n = 0;
        while (!fetch_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 16);
        repeat (3) @(negedge clk);
        check("timeout_no_req", {imem.req, inst_valid}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ret = 0;
        exp_q.push_back(32'h0);
        wait_req(e);
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        rst = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata = 32'h1234_5678;
        @(negedge clk);
        imem.rvalid = 1'b0;
        check("rst_wait_inst", inst, 32'h13);
        check("rst_wait_valid", {inst_valid, imem.req}, 2'b00);
        check("rst_wait_pc", pc, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {imem.req, imem.addr}, {1'b1, 32'h0});
        exp_q.push_back(32'h0);
        fetch(32'h00a0_0113, 0, 1, 0);
        do_commit(2'b00, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
